// File: rtl/dice_pkg.sv
// Shared dice definitions: die codes, face counts and the scheduler state encoding.
package dice_pkg;

  localparam logic [1:0] DIE_D4  = 2'b00;
  localparam logic [1:0] DIE_D6  = 2'b01;
  localparam logic [1:0] DIE_D8  = 2'b10;
  localparam logic [1:0] DIE_D20 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  function automatic logic [7:0] die_faces(input logic [1:0] code);
    case (code)
      DIE_D4:  die_faces = 8'd4;
      DIE_D6:  die_faces = 8'd6;
      DIE_D8:  die_faces = 8'd8;
      default: die_faces = 8'd20;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter
  import dice_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Round-robin scheduler sharing one dice roller among N_REQ requesters, with roll timeout.
// Optional range check of returned values enabled by defining DICE_SCHED_RANGE_CHECK_EN.
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int TO_W           = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_die,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           result,
  output logic                 result_err,
  output logic                 busy,
  output logic                 roll_o,
  output logic [1:0]           die_select_o,
  input  logic                 roll_done_i,
  input  logic [7:0]           rolled_number_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [TO_W-1:0]  timeout_cnt;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_req;
  logic             expired;
  logic             range_err;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_req = |grant;
  assign expired = (timeout_cnt == TO_MAX);

`ifdef DICE_SCHED_RANGE_CHECK_EN
  assign range_err = (rolled_number_i == 8'd0) || (rolled_number_i > die_faces(die_select_o));
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (roll_done_i || expired) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Completion takes priority over timeout when both land in the same WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      winner       <= '0;
      die_select_o <= 2'b00;
      timeout_cnt  <= '0;
      result       <= 8'd0;
      result_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            winner       <= grant_idx;
            die_select_o <= req_die[{grant_idx, 1'b0} +: 2];
          end
        end
        ST_ISSUE: timeout_cnt <= '0;
        ST_WAIT: begin
          if (roll_done_i) begin
            result     <= rolled_number_i;
            result_err <= range_err;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (expired) begin
              result     <= 8'd0;
              result_err <= 1'b1;
            end
          end
        end
        ST_RESP: rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        default: ;
      endcase
    end
  end

  assign roll_o = (state == ST_ISSUE);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    ack = '0;
    if (state == ST_RESP) ack[winner] = 1'b1;
  end

endmodule
